// File: rtl/iob_axi_master_bridge.sv
// Native valid/ready request to single-beat AXI4 master bridge.
// Optional AXI_RESP_ERR_EN adds a sticky err output for SLVERR/DECERR responses.
`ifndef DDR_ADDR_W
`define DDR_ADDR_W 32
`endif

module iob_axi_master_bridge #(
    parameter int ADDR_W = `DDR_ADDR_W,
    parameter int DATA_W = 32,
    parameter int AXI_ID = 0,
    parameter int ID_W   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
`ifdef AXI_RESP_ERR_EN
    output logic                err,
`endif
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [ID_W-1:0]     m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [ID_W-1:0]     m_axi_arid,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arlock,
    output logic [3:0]          m_axi_arcache,
    output logic [2:0]          m_axi_arprot,
    output logic [3:0]          m_axi_arqos,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic [ID_W-1:0]     m_axi_rid,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [2:0] SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;

    // Single-beat fixed attributes
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awid    = ID_W'(AXI_ID);
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b010;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arid    = ID_W'(AXI_ID);
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b010;
    assign m_axi_arqos   = 4'd0;

    // IDs, rlast and the sub-word address bits carry no information here
`ifdef AXI_RESP_ERR_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, m_axi_bid, m_axi_rid, m_axi_rlast, addr[1:0]};
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, m_axi_bid, m_axi_rid, m_axi_rlast,
                         addr[1:0], m_axi_bresp, m_axi_rresp};
`endif

    // Transaction FSM; all handshake outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rdata         <= '0;
            ready         <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
`ifdef AXI_RESP_ERR_EN
            err           <= 1'b0;
`endif
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    // ready=1 marks the cycle whose request was just served
                    if (valid && !ready) begin
                        addr_q <= {addr[ADDR_W-1:2], 2'b00};
                        if (|wstrb) begin
                            wdata_q       <= wdata;
                            wstrb_q       <= wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WADDR;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) &&
                        (!m_axi_wvalid  || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        ready        <= 1'b1;
                        state        <= IDLE;
`ifdef AXI_RESP_ERR_EN
                        if (m_axi_bresp != 2'b00) err <= 1'b1;
`endif
                    end
                end
                RADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        ready        <= 1'b1;
                        state        <= IDLE;
`ifdef AXI_RESP_ERR_EN
                        if (m_axi_rresp != 2'b00) begin
                            rdata <= '0;
                            err   <= 1'b1;
                        end else begin
                            rdata <= m_axi_rdata;
                        end
`else
                        rdata <= m_axi_rdata;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_axi_master_bridge.sv
// Directed bench for iob_axi_master_bridge with a small AXI RAM slave model.
// Build with +define+AXI_RESP_ERR_EN to also exercise the error path.
`timescale 1ns/1ps

module tb_iob_axi_master_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
`ifdef AXI_RESP_ERR_EN
    logic        err;
`endif
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [0:0]  m_axi_awid;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic [3:0]  m_axi_awqos;
    logic        m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_bvalid, m_axi_bready;
    logic [0:0]  m_axi_bid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [0:0]  m_axi_arid;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_rvalid, m_axi_rready;
    logic [0:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_axi_master_bridge #(.ADDR_W(32), .DATA_W(32), .AXI_ID(0), .ID_W(1)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready),
`ifdef AXI_RESP_ERR_EN
        .err(err),
`endif
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awqos(m_axi_awqos),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arqos(m_axi_arqos),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
    );

    int         aw_delay = 0;
    logic       b_hold = 1'b0;
    logic [1:0] rresp_cfg = 2'b00;

    logic [31:0] mem [0:15];
    int          aw_cnt;
    logic        got_aw, got_w;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    assign m_axi_awready = (aw_cnt >= aw_delay);
    assign m_axi_wready  = 1'b1;
    assign m_axi_arready = 1'b1;
    assign m_axi_bid     = 1'b0;
    assign m_axi_bresp   = 2'b00;
    assign m_axi_rid     = 1'b0;
    assign m_axi_rlast   = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt       <= 0;
            got_aw       <= 1'b0;
            got_w        <= 1'b0;
            m_axi_bvalid <= 1'b0;
            m_axi_rvalid <= 1'b0;
            m_axi_rdata  <= '0;
            m_axi_rresp  <= 2'b00;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                got_aw     <= 1'b1;
                cap_awaddr <= m_axi_awaddr;
                aw_cnt     <= 0;
            end else if (m_axi_awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                got_w     <= 1'b1;
                cap_wdata <= m_axi_wdata;
                cap_wstrb <= m_axi_wstrb;
            end
            if (got_aw && got_w && !m_axi_bvalid && !b_hold) begin
                m_axi_bvalid <= 1'b1;
                got_aw       <= 1'b0;
                got_w        <= 1'b0;
                for (int i = 0; i < 4; i++)
                    if (cap_wstrb[i])
                        mem[cap_awaddr[5:2]][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= mem[m_axi_araddr[5:2]];
                m_axi_rresp  <= rresp_cfg;
                cap_araddr   <= m_axi_araddr;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        end
    end

    int aw_cyc = 0, w_cyc = 0, aw_hs = 0, w_hs = 0, b_hs = 0, rdy_cnt = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (m_axi_awvalid) aw_cyc <= aw_cyc + 1;
            if (m_axi_wvalid) w_cyc <= w_cyc + 1;
            if (m_axi_awvalid && m_axi_awready) aw_hs <= aw_hs + 1;
            if (m_axi_wvalid && m_axi_wready) w_hs <= w_hs + 1;
            if (m_axi_bvalid && m_axi_bready) b_hs <= b_hs + 1;
            if (ready) rdy_cnt <= rdy_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd = '0;
        valid = 1'b1;
        addr = a;
        wdata = d;
        wstrb = s;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                got = 1'b1;
                rd = rdata;
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $error("FAIL ready_seen: wait expired for addr %0h", a);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        chk("no_reaccept", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
        chk("ready_one_cycle", ready, 1'b0);
    endtask

    int aw0, w0, awh0, wh0, bh0, r0;
    logic [31:0] rd;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                           m_axi_arvalid, m_axi_rready, ready}, 6'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("const_len", {m_axi_awlen, m_axi_arlen}, 16'h0);
        chk("const_size", {m_axi_awsize, m_axi_arsize}, 6'b010_010);
        chk("const_burst", {m_axi_awburst, m_axi_arburst}, 4'b0101);
        chk("const_cache", {m_axi_awcache, m_axi_arcache}, 8'h33);
        chk("const_prot", {m_axi_awprot, m_axi_arprot}, 6'b010_010);
        chk("const_misc", {m_axi_awlock, m_axi_arlock, m_axi_awqos,
                           m_axi_arqos, m_axi_awid, m_axi_arid, m_axi_wlast},
                          15'b000000000000001);
        rst = 1'b0;
        @(posedge clk); #1;

        aw0 = aw_cyc; w0 = w_cyc; awh0 = aw_hs; wh0 = w_hs; bh0 = b_hs; r0 = rdy_cnt;
        do_req(32'h40, 32'hDEADBEEF, 4'hF, rd);
        chk("t1_awaddr", cap_awaddr, 32'h40);
        chk("t1_wdata", cap_wdata, 32'hDEADBEEF);
        chk("t1_aw_hs", aw_hs - awh0, 1);
        chk("t1_w_hs", w_hs - wh0, 1);
        chk("t1_b_hs", b_hs - bh0, 1);
        chk("t1_ready", rdy_cnt - r0, 1);

        r0 = rdy_cnt;
        do_req(32'h40, 32'h0, 4'h0, rd);
        chk("t2_araddr", cap_araddr, 32'h40);
        chk("t2_rdata", rd, 32'hDEADBEEF);
        chk("t2_ready", rdy_cnt - r0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_hold", rdata, 32'hDEADBEEF);

        aw_delay = 5;
        aw0 = aw_cyc; w0 = w_cyc; bh0 = b_hs; r0 = rdy_cnt;
        do_req(32'h44, 32'h11223344, 4'hF, rd);
        chk("t3_aw_cycles", aw_cyc - aw0, 6);
        chk("t3_w_cycles", w_cyc - w0, 1);
        chk("t3_b_hs", b_hs - bh0, 1);
        chk("t3_ready", rdy_cnt - r0, 1);
        aw_delay = 0;

        do_req(32'h41, 32'h0000AB00, 4'b0010, rd);
        chk("t4_awaddr", cap_awaddr, 32'h40);
        chk("t4_wstrb", cap_wstrb, 4'b0010);
        do_req(32'h40, 32'h0, 4'h0, rd);
        chk("t4_rdata", rd, 32'hDEADABEF);

        b_hold = 1'b1;
        valid = 1'b1;
        addr = 32'h48;
        wdata = 32'h55AA55AA;
        wstrb = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_in_wresp", {m_axi_bready, m_axi_awvalid, m_axi_wvalid}, 3'b100);
        valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_outs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                            m_axi_arvalid, m_axi_rready, ready}, 6'b0);
        chk("t5_rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        b_hold = 1'b0;
        @(posedge clk); #1;
        do_req(32'h40, 32'h0, 4'h0, rd);
        chk("t5_read", rd, 32'hDEADABEF);

`ifdef AXI_RESP_ERR_EN
        chk("t6_err_clear", err, 1'b0);
        rresp_cfg = 2'b10;
        r0 = rdy_cnt;
        do_req(32'h40, 32'h0, 4'h0, rd);
        chk("t6_ready", rdy_cnt - r0, 1);
        chk("t6_rdata", rd, 32'h0);
        chk("t6_err", err, 1'b1);
        rresp_cfg = 2'b00;
        do_req(32'h4C, 32'h01020304, 4'hF, rd);
        chk("t6_err_sticky", err, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
